fft_result_unloader: RTL and testbench



---
 rtl/fft_result_unloader.sv | 127 ++++++++++++
 tb/tb_fft_result_unloader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_unloader.sv
// Drains the FFT working memory after the core finishes, restoring natural bin order,
// and streams each complex sample with its magnitude-squared over a valid/ready port.
module fft_result_unloader #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 5,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]   rd_real,
  input  logic [DATA_WIDTH-1:0]   rd_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_real,
  output logic [DATA_WIDTH-1:0]   out_imag,
  output logic [ADDR_WIDTH-1:0]   out_index,
  output logic [2*DATA_WIDTH:0]   out_mag_sq,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);
  localparam int MW = 2*DATA_WIDTH+1;
  localparam logic [ADDR_WIDTH-1:0] LAST_K = '1;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;
  state_t state;

  logic [ADDR_WIDTH:0]            issue_k;
  logic                           inflight;
  logic [ADDR_WIDTH-1:0]          inflight_k;
  logic [DATA_WIDTH-1:0]          fifo_real [2];
  logic [DATA_WIDTH-1:0]          fifo_imag [2];
  logic [ADDR_WIDTH-1:0]          fifo_index [2];
  logic [MW-1:0]                  fifo_mag [2];
  logic                           wr_ptr;
  logic                           rd_ptr;
  logic [1:0]                     fifo_count;
  logic                           pop;
  logic                           issue;
  logic signed [2*DATA_WIDTH-1:0] re_ext, im_ext, re_sq, im_sq;
  logic [MW-1:0]                  cap_mag;

  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] k);
    logic [ADDR_WIDTH-1:0] r;
    r = k;
    if (BIT_REVERSE)
      for (int i = 0; i < ADDR_WIDTH; i++) r[i] = k[ADDR_WIDTH-1-i];
    return r;
  endfunction

  assign out_valid  = (fifo_count != 2'd0);
  assign pop        = out_valid & out_ready;
  assign out_real   = fifo_real[rd_ptr];
  assign out_imag   = fifo_imag[rd_ptr];
  assign out_index  = fifo_index[rd_ptr];
  assign out_mag_sq = fifo_mag[rd_ptr];
  assign out_last   = out_valid && (out_index == LAST_K);
  assign busy       = (state == STREAM);
  assign done       = (state == FINISH);

  // Issue is combinational on pop so a freed slot refills in the same cycle,
  // which is what lets the 2-entry budget sustain one beat per clock.
  assign issue   = (state == STREAM) && !issue_k[ADDR_WIDTH] &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign rd_en   = issue;
  assign rd_addr = map_addr(issue_k[ADDR_WIDTH-1:0]);

  // Squares of sign-extended operands are never negative, so zero-extending the sum is exact.
  assign re_ext  = {{DATA_WIDTH{rd_real[DATA_WIDTH-1]}}, rd_real};
  assign im_ext  = {{DATA_WIDTH{rd_imag[DATA_WIDTH-1]}}, rd_imag};
  assign re_sq   = re_ext * re_ext;
  assign im_sq   = im_ext * im_ext;
  assign cap_mag = {1'b0, re_sq} + {1'b0, im_sq};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      issue_k <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= STREAM;
          issue_k <= '0;
        end
        STREAM: begin
          if (issue) issue_k <= issue_k + 1'b1;
          if (pop && (out_index == LAST_K)) state <= FINISH;
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after the strobe; inflight marks that cycle for the push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= 1'b0;
      inflight_k <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_real[i]  <= '0;
        fifo_imag[i]  <= '0;
        fifo_index[i] <= '0;
        fifo_mag[i]   <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) inflight_k <= issue_k[ADDR_WIDTH-1:0];
      if (inflight) begin
        fifo_real[wr_ptr]  <= rd_real;
        fifo_imag[wr_ptr]  <= rd_imag;
        fifo_index[wr_ptr] <= inflight_k;
        fifo_mag[wr_ptr]   <= cap_mag;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fft_result_unloader.sv
// Bench for fft_result_unloader: behavioural memory, natural-order reference model and
// directed sequences with randomized data and backpressure.
module tb_fft_result_unloader;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_real = '0;
  logic [DW-1:0] rd_imag = '0;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_real, out_imag;
  logic [AW-1:0] out_index;
  logic [2*DW:0] out_mag_sq;
  logic          out_last, busy, done;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];
  logic [2*DW:0]        seen_mag [N];

  int checks = 0;
  int passed = 0;
  int failed = 0;
  int issued_cnt = 0;
  int popped_cnt = 0;
  int max_outstanding = 0;

  always #5 clk = ~clk;

  fft_result_unloader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REVERSE(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_real(rd_real), .rd_imag(rd_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
    .out_mag_sq(out_mag_sq), .out_last(out_last), .busy(busy), .done(done)
  );

  // Synchronous read memory with one cycle of latency
  always @(posedge clk) begin
    if (rd_en) begin
      rd_real <= mem_re[rd_addr];
      rd_imag <= mem_im[rd_addr];
    end
  end

  // Reads issued but not yet handed to the consumer
  always @(posedge clk) begin
    if (reset) begin
      issued_cnt = 0;
      popped_cnt = 0;
    end else begin
      if (rd_en) issued_cnt++;
      if (out_valid && out_ready) popped_cnt++;
      if (issued_cnt - popped_cnt > max_outstanding) max_outstanding = issued_cnt - popped_cnt;
    end
  end

  function automatic int bit_rev(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++) r = r * 2 + ((k >> i) % 2);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < N; a++) begin
      mem_re[a] = 16'(a);
      mem_im[a] = 16'(-a);
    end
  endtask

  task automatic run_stream(input bit random_ready, input int abort_at,
                            input bit second_start, input bit check_timing);
    int beat = 0;
    int cyc = 0;
    int done_count = 0;
    int done_cyc = -1;
    bit restart_used = 0;
    int addr;
    logic [DW-1:0] exp_re, exp_im;
    longint re_l, im_l;
    max_outstanding = 0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    while (cyc < 400 && !(done_count > 0 && cyc > done_cyc + 3)) begin
      start = 1'b0;
      if (second_start && beat == 5 && !restart_used) begin
        start = 1'b1;
        restart_used = 1;
      end
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 0) begin
        check_output("busy_after_start", busy, 1);
        check_output("rd_en_after_start", rd_en, 1);
        check_output("valid_too_early", out_valid, 0);
      end
      if (check_timing && cyc == 2) check_output("first_valid", out_valid, 1);
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (out_valid && beat < N) begin
        addr = bit_rev(beat);
        exp_re = mem_re[addr];
        exp_im = mem_im[addr];
        re_l = longint'(mem_re[addr]);
        im_l = longint'(mem_im[addr]);
        check_output("index", out_index, beat);
        check_output("real", out_real, exp_re);
        check_output("imag", out_imag, exp_im);
        check_output("mag_sq", out_mag_sq, re_l * re_l + im_l * im_l);
        check_output("last", out_last, (beat == N - 1));
        if (out_ready) begin
          seen_mag[beat] = out_mag_sq;
          beat++;
        end
      end else if (out_valid) begin
        check_output("extra_beat", out_valid, 0);
      end
      if (abort_at > 0 && beat == abort_at) return;
      @(negedge clk);
      cyc++;
    end
    check_output("beat_count", beat, N);
    check_output("done_pulses", done_count, 1);
    check_output("outstanding_le_2", (max_outstanding <= 2), 1);
    if (check_timing) check_output("done_cycle", done_cyc, N + 2);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    fill_ramp();
    repeat (2) @(negedge clk);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_rd_en", rd_en, 0);
    check_output("rst_rd_addr", rd_addr, 0);
    check_output("rst_data", {out_real, out_imag, out_index, out_mag_sq, out_last}, 0);
    check_output("rst_busy_done", {busy, done}, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("idle_quiet", {out_valid, rd_en, busy, done}, 0);
    end

    $display("[TB] full-rate stream");
    run_stream(1'b0, 0, 1'b0, 1'b1);

    $display("[TB] backpressure stream");
    run_stream(1'b1, 0, 1'b0, 1'b0);

    $display("[TB] random data and magnitude corners");
    for (int a = 0; a < N; a++) begin
      mem_re[a] = 16'($urandom);
      mem_im[a] = 16'($urandom);
    end
    mem_re[0]  = -16'sd32768;
    mem_im[0]  = -16'sd32768;
    mem_re[16] = 16'sd3;
    mem_im[16] = -16'sd4;
    run_stream(1'b1, 0, 1'b0, 1'b0);
    check_output("mag_corner_0", seen_mag[0], 64'd2147483648);
    check_output("mag_corner_1", seen_mag[1], 64'd25);

    $display("[TB] mid-stream reset");
    fill_ramp();
    run_stream(1'b0, 10, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_output("midrst_valid_rd", {out_valid, rd_en}, 0);
    check_output("midrst_busy_done", {busy, done}, 0);
    check_output("midrst_data", {out_real, out_imag, out_index, out_mag_sq, out_last}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("post_rst_idle", {out_valid, rd_en, busy}, 0);
    run_stream(1'b0, 0, 1'b0, 1'b1);

    $display("[TB] start while busy");
    run_stream(1'b0, 0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
